sdram_cache: RTL and testbench

- Direct-mapped, write-through, single-word-line read cache between the CPU iomem bus and the SDRAM controller's cpu/chipset port.
- Read hits are served in 2 cycles instead of a full SDRAM access.
- Writes always go to SDRAM. On a hit they also update the cached word; a write miss does not allocate a line.
- Sits directly upstream of the SDRAM controller. It replaces the direct sdram_sel/sdram_rdata/sdram_ready hookup in the SoC.

---
 rtl/sdram_cache_pkg.sv | 19 +
 rtl/sdram_cache_ram.sv | 33 +++
 rtl/sdram_cache.sv | 224 ++++++++++++++++++++++
 tb/tb_sdram_cache.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cache_pkg.sv
// Shared state encoding and width helpers for the direct-mapped SDRAM read cache.
package sdram_cache_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    FILL,
    WRITE,
    RESP,
    FLUSH
  } state_t;

  function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                           input int unsigned idx_bits);
    return addr_bits - idx_bits - 2;
  endfunction

endpackage

// File: rtl/sdram_cache_ram.sv
// Single-port synchronous tag/data store; read-first, byte-enabled data writes.
module sdram_cache_ram #(
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned TAG_BITS = 16
) (
  input  logic                i_clk,
  input  logic [IDX_BITS-1:0] i_idx,
  input  logic                i_tag_we,
  input  logic [3:0]          i_be,
  input  logic [TAG_BITS-1:0] i_tag,
  input  logic [31:0]         i_data,
  output logic [TAG_BITS-1:0] o_tag,
  output logic [31:0]         o_data
);
  localparam int unsigned DEPTH = 1 << IDX_BITS;

  logic [TAG_BITS-1:0] r_tag_mem  [DEPTH];
  logic [31:0]         r_data_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_tag_we) begin
      r_tag_mem[i_idx] <= i_tag;
    end
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        r_data_mem[i_idx][8*b +: 8] <= i_data[8*b +: 8];
      end
    end
    o_tag  <= r_tag_mem[i_idx];
    o_data <= r_data_mem[i_idx];
  end

endmodule

// File: rtl/sdram_cache.sv
// Direct-mapped write-through single-word-line read cache in front of the SDRAM controller.
module sdram_cache
  import sdram_cache_pkg::*;
#(
  parameter int unsigned IDX_BITS  = 8,
  parameter int unsigned ADDR_BITS = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 ready,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [3:0]           wstrb,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic                 flush,
  output logic                 busy,
  output logic                 mem_oe,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [3:0]           mem_dqm,
  output logic [31:0]          mem_din,
  input  logic [31:0]          mem_dout,
  input  logic                 mem_ready,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);
  localparam int unsigned TAG_BITS = tag_bits(ADDR_BITS, IDX_BITS);
  localparam int unsigned WA_BITS  = ADDR_BITS - 2;
  localparam int unsigned LINES    = 1 << IDX_BITS;

  state_t               r_state, w_state_n;
  logic [IDX_BITS-1:0]  r_ptr, w_ptr_n;
  logic [LINES-1:0]     r_vld, w_vld_n;
  logic                 r_pend, w_pend_n;
  logic [WA_BITS-1:0]   r_waddr, w_waddr_n;
  logic [3:0]           r_wstrb, w_wstrb_n;
  logic [31:0]          r_wdata, w_wdata_n;

  logic                 w_ready_n, w_busy_n, w_oe_n, w_we_n;
  logic [ADDR_BITS-1:0] w_maddr_n;
  logic [3:0]           w_dqm_n;
  logic [31:0]          w_rdata_n, w_din_n, w_hit_cnt_n, w_miss_cnt_n;

  logic [IDX_BITS-1:0]  w_idx, w_ram_idx;
  logic [TAG_BITS-1:0]  w_tag, w_ram_tag_q;
  logic [31:0]          w_ram_data, w_ram_data_q;
  logic                 w_ram_tag_we;
  logic [3:0]           w_ram_be;
  logic                 w_hit;
  logic                 w_unused;

  assign w_idx    = r_waddr[IDX_BITS-1:0];
  assign w_tag    = r_waddr[WA_BITS-1:IDX_BITS];
  assign w_hit    = r_vld[w_idx] && (w_ram_tag_q == w_tag);
  assign w_unused = ^addr[1:0];

  sdram_cache_ram #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_ram (
    .i_clk    (clk),
    .i_idx    (w_ram_idx),
    .i_tag_we (w_ram_tag_we),
    .i_be     (w_ram_be),
    .i_tag    (w_tag),
    .i_data   (w_ram_data),
    .o_tag    (w_ram_tag_q),
    .o_data   (w_ram_data_q)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_n    = r_state;
    w_ptr_n      = r_ptr;
    w_vld_n      = r_vld;
    w_pend_n     = r_pend | flush;
    w_waddr_n    = r_waddr;
    w_wstrb_n    = r_wstrb;
    w_wdata_n    = r_wdata;
    w_ready_n    = 1'b0;
    w_busy_n     = busy;
    w_oe_n       = mem_oe;
    w_we_n       = mem_we;
    w_maddr_n    = mem_addr;
    w_dqm_n      = mem_dqm;
    w_rdata_n    = rdata;
    w_din_n      = mem_din;
    w_hit_cnt_n  = hit_cnt;
    w_miss_cnt_n = miss_cnt;
    w_ram_idx    = w_idx;
    w_ram_tag_we = 1'b0;
    w_ram_be     = 4'h0;
    w_ram_data   = r_wdata;

    case (r_state)
      INIT, FLUSH: begin
        w_vld_n[r_ptr] = 1'b0;
        w_pend_n       = 1'b0;
        if (flush) begin
          w_ptr_n = '0;
        end else if (r_ptr == IDX_BITS'(LINES - 1)) begin
          w_ptr_n   = '0;
          w_busy_n  = 1'b0;
          w_state_n = IDLE;
        end else begin
          w_ptr_n = r_ptr + IDX_BITS'(1);
        end
      end

      IDLE: begin
        w_ram_idx = addr[IDX_BITS+1:2];
        if (r_pend || flush) begin
          w_pend_n  = 1'b0;
          w_ptr_n   = '0;
          w_busy_n  = 1'b1;
          w_state_n = FLUSH;
        end else if (valid && !ready) begin
          w_waddr_n = addr[ADDR_BITS-1:2];
          w_wstrb_n = wstrb;
          w_wdata_n = wdata;
          w_state_n = LOOKUP;
        end
      end

      LOOKUP: begin
        w_maddr_n = {r_waddr, 2'b00};
        if (r_wstrb == 4'h0) begin
          if (w_hit) begin
            w_ready_n   = 1'b1;
            w_rdata_n   = w_ram_data_q;
            w_hit_cnt_n = hit_cnt + 32'd1;
            w_state_n   = RESP;
          end else begin
            w_miss_cnt_n = miss_cnt + 32'd1;
            w_oe_n       = 1'b1;
            w_dqm_n      = 4'h0;
            w_state_n    = FILL;
          end
        end else begin
          // Write-through; a hit also merges the enabled bytes into the line
          w_we_n    = 1'b1;
          w_din_n   = r_wdata;
          w_dqm_n   = ~r_wstrb;
          w_state_n = WRITE;
          if (w_hit) begin
            w_ram_be = r_wstrb;
          end
        end
      end

      FILL: begin
        if (mem_ready) begin
          w_oe_n         = 1'b0;
          w_ram_tag_we   = 1'b1;
          w_ram_be       = 4'hF;
          w_ram_data     = mem_dout;
          w_vld_n[w_idx] = 1'b1;
          w_rdata_n      = mem_dout;
          w_ready_n      = 1'b1;
          w_state_n      = RESP;
        end
      end

      WRITE: begin
        if (mem_ready) begin
          w_we_n    = 1'b0;
          w_dqm_n   = 4'hF;
          w_ready_n = 1'b1;
          w_state_n = RESP;
        end
      end

      RESP: begin
        w_state_n = IDLE;
      end

      default: begin
        w_state_n = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= INIT;
      r_ptr    <= '0;
      r_vld    <= '0;
      r_pend   <= 1'b0;
      r_waddr  <= '0;
      r_wstrb  <= 4'h0;
      r_wdata  <= 32'h0;
      ready    <= 1'b0;
      rdata    <= 32'h0;
      busy     <= 1'b1;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_dqm  <= 4'hF;
      mem_din  <= 32'h0;
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      r_state  <= w_state_n;
      r_ptr    <= w_ptr_n;
      r_vld    <= w_vld_n;
      r_pend   <= w_pend_n;
      r_waddr  <= w_waddr_n;
      r_wstrb  <= w_wstrb_n;
      r_wdata  <= w_wdata_n;
      ready    <= w_ready_n;
      rdata    <= w_rdata_n;
      busy     <= w_busy_n;
      mem_oe   <= w_oe_n;
      mem_we   <= w_we_n;
      mem_addr <= w_maddr_n;
      mem_dqm  <= w_dqm_n;
      mem_din  <= w_din_n;
      hit_cnt  <= w_hit_cnt_n;
      miss_cnt <= w_miss_cnt_n;
    end
  end

endmodule

// File: tb/tb_sdram_cache.sv
// Self-checking bench for sdram_cache: vector table, scoreboard, flush and reset corner cases.
module tb_sdram_cache;

  localparam int LAT = 5;

  typedef struct {
    logic [25:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          hit;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, valid, flush, mem_ready;
  logic [25:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata, mem_dout;
  logic        ready, busy, mem_oe, mem_we;
  logic [31:0] rdata, mem_din, hit_cnt, miss_cnt;
  logic [25:0] mem_addr;
  logic [3:0]  mem_dqm;

  int total = 0;
  int bad = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int oe_cycles = 0;
  int busy_act = 0;
  int mcnt = 0;
  logic [3:0]  last_dqm;
  logic [25:0] last_waddr;
  logic [31:0] last_din;
  logic [31:0] mem_model [int unsigned];
  exp_t        sb[$];
  vec_t        vecs[11];

  sdram_cache dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .ready     (ready),
    .addr      (addr),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .rdata     (rdata),
    .flush     (flush),
    .busy      (busy),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dqm   (mem_dqm),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [25:0] a);
    int unsigned k;
    k = 32'(a);
    if (mem_model.exists(k)) return mem_model[k];
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  // SDRAM controller model: completes each strobe after LAT sampled cycles
  always @(negedge clk) begin
    logic [31:0] cur;
    if (reset) begin
      mem_ready = 1'b0;
      mcnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      mcnt = 0;
    end else if (mem_oe || mem_we) begin
      mcnt++;
      if (mem_oe) oe_cycles++;
      if (mcnt == LAT) begin
        if (mem_oe) begin
          mem_dout = rd_model(mem_addr);
        end else begin
          cur = rd_model(mem_addr);
          for (int b = 0; b < 4; b++) begin
            if (!mem_dqm[b]) cur[8*b +: 8] = mem_din[8*b +: 8];
          end
          mem_model[32'(mem_addr)] = cur;
          last_dqm   = mem_dqm;
          last_waddr = mem_addr;
          last_din   = mem_din;
        end
        mem_ready = 1'b1;
      end
    end
  end

  // Scoreboard consumer and bus-quiet-while-busy monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && busy && (mem_oe || mem_we)) busy_act++;
    if (ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready=1 want no response");
      end else begin
        e = sb.pop_front();
        if (e.chk) check("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic do_req(input logic [25:0] a, input logic [3:0] s, input logic [31:0] d,
                        input logic [31:0] e, output int lat);
    @(negedge clk);
    oe_cycles = 0;
    valid = 1'b1;
    addr  = a;
    wstrb = s;
    wdata = d;
    sb.push_back('{rdata: e, chk: (s == 4'h0)});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 200);
    check("ready_seen", 32'(ready), 32'd1);
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit rd;
    logic [3:0] dq;
    rd = (v.wstrb == 4'h0);
    dq = ~v.wstrb;
    do_req(v.addr, v.wstrb, v.wdata, v.exp, lat);
    if (rd) begin
      if (v.hit) exp_hits++;
      else exp_misses++;
    end
    check("latency", 32'(lat), (rd && v.hit) ? 32'd2 : 32'd7);
    check("oe_cycles", 32'(oe_cycles), (rd && !v.hit) ? 32'(LAT) : 32'd0);
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_misses));
    if (!rd) begin
      check("wr_dqm", 32'(last_dqm), 32'(dq));
      check("wr_addr", 32'(last_waddr), 32'(v.addr));
      check("wr_din", last_din, v.wdata);
    end
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 1000);
    check(name, 32'(n), 32'd256);
  endtask

  task automatic check_reset_state();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_oe", 32'(mem_oe), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'h0);
    check("rst_dqm", 32'(mem_dqm), 32'hF);
    check("rst_din", mem_din, 32'h0);
    check("rst_hit", hit_cnt, 32'h0);
    check("rst_miss", miss_cnt, 32'h0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    vec_t v;
    int n;
    vecs[0]  = '{26'h0000100, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{26'h0000100, 4'h0, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[2]  = '{26'h0000100, 4'h2, 32'h0000AA00, 32'h0,        1'b1};
    vecs[3]  = '{26'h0000100, 4'h0, 32'h0,        32'hDEADAAEF, 1'b1};
    vecs[4]  = '{26'h0000500, 4'h0, 32'h0,        32'h12345678, 1'b0};
    vecs[5]  = '{26'h0000100, 4'h0, 32'h0,        32'hDEADAAEF, 1'b0};
    vecs[6]  = '{26'h0000204, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[7]  = '{26'h0000204, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[8]  = '{26'h0000204, 4'h0, 32'h0,        32'hCAFEF00D, 1'b1};
    vecs[9]  = '{26'h3FFFFFC, 4'h0, 32'h0,        32'hA6FFFFFC, 1'b0};
    vecs[10] = '{26'h3FFFFFC, 4'h0, 32'h0,        32'hA6FFFFFC, 1'b1};

    mem_model[32'h100] = 32'hDEADBEEF;
    mem_model[32'h500] = 32'h12345678;

    reset = 1'b1;
    valid = 1'b0;
    flush = 1'b0;
    addr = '0;
    wstrb = 4'h0;
    wdata = 32'h0;
    mem_ready = 1'b0;
    mem_dout = 32'h0;

    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    wait_sweep("init_sweep_len");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush pulsed while a fill is outstanding
    v = '{26'h0000600, 4'h0, 32'h0, 32'hA5000600, 1'b0};
    fork
      run_vec(v);
      begin
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("flush_busy", 32'(busy), 32'd1);
    wait_sweep("flush_sweep_len");
    run_vec('{26'h0000204, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0});

    // Reset while a write is waiting on the controller
    @(negedge clk);
    valid = 1'b1;
    addr  = 26'h0000208;
    wstrb = 4'hF;
    wdata = 32'h11112222;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_we && n < 20);
    check("we_started", 32'(mem_we), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    wstrb = 4'h0;
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk);
    check("rst_we_drop", 32'(mem_we), 32'd0);
    check("rst_no_ready", 32'(ready), 32'd0);
    check("rst_busy_hi", 32'(busy), 32'd1);
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    wait_sweep("reinit_sweep_len");
    run_vec('{26'h0000208, 4'h0, 32'h0, 32'hA5000208, 1'b0});
    run_vec('{26'h0000204, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0});
    run_vec('{26'h0000204, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1});
    run_vec('{26'h0000100, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0});

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("busy_bus_activity", 32'(busy_act), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
